// File: rtl/arbitro_memoria_dados_if.sv
// Barramento do arbitro: os dois requisitantes e a porta unica da memoria de dados.
// slave = lado do arbitro; master = requisitantes e memoria.
interface arbitro_memoria_dados_if #(
    parameter int LARGURA_END  = 8,
    parameter int LARGURA_DADO = 8
);
    logic                    Req0;
    logic                    Req1;
    logic                    Escr0;
    logic                    Escr1;
    logic [LARGURA_END-1:0]  Endereco0;
    logic [LARGURA_END-1:0]  Endereco1;
    logic [LARGURA_DADO-1:0] Dado0;
    logic [LARGURA_DADO-1:0] Dado1;
    logic                    Concedido0;
    logic                    Concedido1;
    logic                    Pronto0;
    logic                    Pronto1;
    logic [LARGURA_DADO-1:0] DadoLido0;
    logic [LARGURA_DADO-1:0] DadoLido1;
    logic                    Ocupado;
    logic [LARGURA_END-1:0]  Endereco;
    logic [LARGURA_DADO-1:0] DadoEscr;
    logic                    MenWrite;
    logic                    MenRead;
    logic [LARGURA_DADO-1:0] DadoLido;

    modport slave (
        input  Req0, Req1, Escr0, Escr1, Endereco0, Endereco1, Dado0, Dado1, DadoLido,
        output Concedido0, Concedido1, Pronto0, Pronto1, DadoLido0, DadoLido1,
               Ocupado, Endereco, DadoEscr, MenWrite, MenRead
    );

    modport master (
        output Req0, Req1, Escr0, Escr1, Endereco0, Endereco1, Dado0, Dado1, DadoLido,
        input  Concedido0, Concedido1, Pronto0, Pronto1, DadoLido0, DadoLido1,
               Ocupado, Endereco, DadoEscr, MenWrite, MenRead
    );
endinterface

// File: rtl/arbitro_memoria_dados.sv
// Arbitro round-robin de duas portas para a memoria de dados de 8 bits:
// serializa leituras/escritas simples e devolve o dado lido com pulso Pronto.
//
// estado  | significado
// OCIOSO  | aguardando Req; escolhe porta e trava endereco/dado/operacao
// ACESSO  | memoria acionada; Concedido da porta escolhida em 1
// CONCLUI | Pronto da porta escolhida em 1; Req ignorados
module arbitro_memoria_dados #(
    parameter int LARGURA_END  = 8,
    parameter int LARGURA_DADO = 8
) (
    input logic                      Clock,
    input logic                      Reset,
    arbitro_memoria_dados_if.slave   barramento
);
    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ACESSO  = 2'd1,
        CONCLUI = 2'd2
    } estado_t;

    estado_t                 estado;
    estado_t                 proximo;
    logic                    ultimo;
    logic                    porta_sel;
    logic                    escr_lat;
    logic [LARGURA_END-1:0]  end_lat;
    logic [LARGURA_DADO-1:0] dado_lat;
    logic [LARGURA_DADO-1:0] lido0;
    logic [LARGURA_DADO-1:0] lido1;
    logic                    escolha;
    logic                    aceita;

    // Empate vai para a porta que nao foi atendida por ultimo.
    assign escolha = (barramento.Req0 && barramento.Req1) ? ~ultimo : barramento.Req1;
    assign aceita  = (estado == OCIOSO) && (barramento.Req0 || barramento.Req1);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ultimo    <= 1'b1;
            porta_sel <= 1'b0;
            escr_lat  <= 1'b0;
            end_lat   <= '0;
            dado_lat  <= '0;
            lido0     <= '0;
            lido1     <= '0;
        end else begin
            if (aceita) begin
                ultimo    <= escolha;
                porta_sel <= escolha;
                escr_lat  <= escolha ? barramento.Escr1     : barramento.Escr0;
                end_lat   <= escolha ? barramento.Endereco1 : barramento.Endereco0;
                dado_lat  <= escolha ? barramento.Dado1     : barramento.Dado0;
            end
            // A memoria entrega o dado na borda de descida do ACESSO.
            if (estado == ACESSO && !escr_lat) begin
                if (porta_sel) begin
                    lido1 <= barramento.DadoLido;
                end else begin
                    lido0 <= barramento.DadoLido;
                end
            end
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:  if (barramento.Req0 || barramento.Req1) proximo = ACESSO;
            ACESSO:  proximo = CONCLUI;
            CONCLUI: proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    always_comb begin
        barramento.Concedido0 = 1'b0;
        barramento.Concedido1 = 1'b0;
        barramento.Pronto0    = 1'b0;
        barramento.Pronto1    = 1'b0;
        barramento.MenWrite   = 1'b0;
        barramento.MenRead    = 1'b0;
        barramento.Ocupado    = (estado != OCIOSO);
        barramento.Endereco   = end_lat;
        barramento.DadoEscr   = dado_lat;
        barramento.DadoLido0  = lido0;
        barramento.DadoLido1  = lido1;
        case (estado)
            ACESSO: begin
                barramento.Concedido0 = ~porta_sel;
                barramento.Concedido1 = porta_sel;
                barramento.MenWrite   = escr_lat;
                barramento.MenRead    = ~escr_lat;
            end
            CONCLUI: begin
                barramento.Pronto0 = ~porta_sel;
                barramento.Pronto1 = porta_sel;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Bancada do arbitro: modelo de transacoes em fila, monitor independente e memoria simples.
module tb_arbitro_memoria_dados;
    bit   Clock;
    logic Reset;
    int   ciclo = 0;
    int   vetores = 0;
    int   erros = 0;

    arbitro_memoria_dados_if #(.LARGURA_END(8), .LARGURA_DADO(8)) barr ();

    arbitro_memoria_dados #(.LARGURA_END(8), .LARGURA_DADO(8)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .barramento (barr)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) ciclo++;

    // Memoria externa: escreve na subida, registra leitura na descida.
    logic [7:0] mem_fis [256] = '{default: 8'h00};
    always @(posedge Clock) if (barr.MenWrite) mem_fis[barr.Endereco] <= barr.DadoEscr;
    always @(negedge Clock) if (barr.MenRead) barr.DadoLido <= mem_fis[barr.Endereco];

    typedef struct {
        int         porta;
        bit         escr;
        logic [7:0] ender;
        logic [7:0] dado;
        logic [7:0] lido0;
        logic [7:0] lido1;
        int         g;
    } esperado_t;

    esperado_t  fila[$];
    esperado_t  e_mon;
    bit         em_curso = 0;

    // Modelo de referencia: ciclo em que o arbitro volta a amostrar, ultima porta, memoria.
    int         livre_mod;
    bit         ultimo_mod;
    logic [7:0] mem_ref [256] = '{default: 8'h00};
    logic [7:0] lido_ref [2];
    logic [7:0] pool [6] = '{8'h00, 8'h3C, 8'h80, 8'hFF, 8'h12, 8'h5A};

    always @(negedge Clock) begin
        if (!Reset) begin
            vetores++;
            if ((barr.MenWrite && barr.MenRead) || (barr.Concedido0 && barr.Concedido1) ||
                (!(barr.Concedido0 || barr.Concedido1) && (barr.MenWrite || barr.MenRead)) ||
                ((barr.Concedido0 || barr.Concedido1) && (barr.Pronto0 || barr.Pronto1)) ||
                (barr.Pronto0 && barr.Pronto1)) begin
                erros++;
                $display("FAIL barramento ciclo %0d: C=%b%b P=%b%b MW=%b MR=%b", ciclo,
                         barr.Concedido1, barr.Concedido0, barr.Pronto1, barr.Pronto0,
                         barr.MenWrite, barr.MenRead);
            end
            if (barr.Concedido0 || barr.Concedido1) begin
                vetores++;
                if (fila.size() == 0) begin
                    erros++;
                    $display("FAIL concessao ciclo %0d: got grant, expected none", ciclo);
                end else begin
                    e_mon = fila[0];
                    if (barr.Concedido1 != (e_mon.porta == 1) || ciclo != e_mon.g ||
                        barr.MenWrite != e_mon.escr || barr.MenRead != !e_mon.escr ||
                        barr.Endereco != e_mon.ender || barr.DadoEscr != e_mon.dado || !barr.Ocupado) begin
                        erros++;
                        $display("FAIL concessao: got porta=%0d ciclo=%0d MW=%b end=%h dado=%h, expected porta=%0d ciclo=%0d MW=%b end=%h dado=%h",
                                 barr.Concedido1, ciclo, barr.MenWrite, barr.Endereco, barr.DadoEscr,
                                 e_mon.porta, e_mon.g, e_mon.escr, e_mon.ender, e_mon.dado);
                    end
                    em_curso = 1;
                end
            end else if (barr.Pronto0 || barr.Pronto1) begin
                vetores++;
                if (!em_curso || fila.size() == 0) begin
                    erros++;
                    $display("FAIL pronto ciclo %0d: got Pronto without grant", ciclo);
                end else begin
                    e_mon = fila.pop_front();
                    em_curso = 0;
                    if (barr.Pronto1 != (e_mon.porta == 1) || ciclo != e_mon.g + 1 ||
                        barr.DadoLido0 != e_mon.lido0 || barr.DadoLido1 != e_mon.lido1 ||
                        barr.Endereco != e_mon.ender || barr.DadoEscr != e_mon.dado || !barr.Ocupado) begin
                        erros++;
                        $display("FAIL pronto: got porta=%0d ciclo=%0d lido0=%h lido1=%h end=%h, expected porta=%0d ciclo=%0d lido0=%h lido1=%h end=%h",
                                 barr.Pronto1, ciclo, barr.DadoLido0, barr.DadoLido1, barr.Endereco,
                                 e_mon.porta, e_mon.g + 1, e_mon.lido0, e_mon.lido1, e_mon.ender);
                    end
                end
            end else if (fila.size() > 0 && ciclo > fila[0].g) begin
                vetores++;
                erros++;
                $display("FAIL evento_ausente ciclo %0d: got no grant/Pronto, expected porta=%0d grant at %0d",
                         ciclo, fila[0].porta, fila[0].g);
                void'(fila.pop_front());
                em_curso = 0;
            end
        end
    end

    task automatic ocioso(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic aplicar_reset(input int n);
        Reset = 1'b1;
        repeat (n) begin
            @(negedge Clock);
            vetores++;
            if ({barr.Concedido0, barr.Concedido1, barr.Pronto0, barr.Pronto1,
                 barr.MenWrite, barr.MenRead, barr.Ocupado} != 7'd0 ||
                barr.Endereco != 8'h00 || barr.DadoEscr != 8'h00 ||
                barr.DadoLido0 != 8'h00 || barr.DadoLido1 != 8'h00) begin
                erros++;
                $display("FAIL reset: got C=%b%b P=%b%b MW=%b MR=%b Oc=%b end=%h de=%h l0=%h l1=%h, expected all 0",
                         barr.Concedido1, barr.Concedido0, barr.Pronto1, barr.Pronto0, barr.MenWrite,
                         barr.MenRead, barr.Ocupado, barr.Endereco, barr.DadoEscr, barr.DadoLido0, barr.DadoLido1);
            end
        end
        fila.delete();
        em_curso    = 0;
        Reset       = 1'b0;
        livre_mod   = ciclo;
        ultimo_mod  = 1'b1;
        lido_ref[0] = 8'h00;
        lido_ref[1] = 8'h00;
    endtask

    // Uma rodada: porta 0 apresenta no ciclo atual, porta 1 "atraso1" ciclos depois.
    task automatic rodada(input bit v0, input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                          input bit v1, input bit w1, input logic [7:0] a1, input logic [7:0] d1,
                          input int atraso1);
        int         c;
        int         s;
        int         w;
        int         espera;
        int         r [2];
        bit         pend [2];
        bit         wv [2];
        logic [7:0] av [2];
        logic [7:0] dv [2];
        bit         feito0;
        bit         feito1;
        bit         ativo1;
        esperado_t  e;

        c = ciclo;
        r[0] = c;  r[1] = c + atraso1;
        pend[0] = v0; pend[1] = v1;
        wv[0] = w0; wv[1] = w1; av[0] = a0; av[1] = a1; dv[0] = d0; dv[1] = d1;
        while (pend[0] || pend[1]) begin
            if (pend[0] && pend[1]) s = (r[0] < r[1]) ? r[0] : r[1];
            else                    s = pend[0] ? r[0] : r[1];
            if (s < livre_mod) s = livre_mod;
            if (pend[0] && pend[1] && r[0] <= s && r[1] <= s) w = ultimo_mod ? 0 : 1;
            else                                               w = (pend[0] && r[0] <= s) ? 0 : 1;
            if (wv[w]) mem_ref[av[w]] = dv[w];
            else       lido_ref[w]    = mem_ref[av[w]];
            e.porta = w;     e.escr = wv[w]; e.ender = av[w]; e.dado = dv[w];
            e.lido0 = lido_ref[0]; e.lido1 = lido_ref[1]; e.g = s + 1;
            fila.push_back(e);
            livre_mod  = s + 3;
            ultimo_mod = (w == 1);
            pend[w]    = 1'b0;
        end

        if (v0) begin
            barr.Req0 = 1'b1; barr.Escr0 = w0; barr.Endereco0 = a0; barr.Dado0 = d0;
        end
        ativo1 = 1'b0;
        if (v1 && atraso1 == 0) begin
            barr.Req1 = 1'b1; barr.Escr1 = w1; barr.Endereco1 = a1; barr.Dado1 = d1;
            ativo1 = 1'b1;
        end
        feito0 = !v0;
        feito1 = !v1;
        espera = 0;
        while (!(feito0 && feito1) && espera < 60) begin
            @(negedge Clock);
            espera++;
            if (!feito0 && barr.Concedido0) begin barr.Req0 = 1'b0; feito0 = 1'b1; end
            if (!feito1 && ativo1 && barr.Concedido1) begin barr.Req1 = 1'b0; feito1 = 1'b1; end
            if (v1 && !ativo1 && ciclo == c + atraso1) begin
                barr.Req1 = 1'b1; barr.Escr1 = w1; barr.Endereco1 = a1; barr.Dado1 = d1;
                ativo1 = 1'b1;
            end
        end
        vetores++;
        if (!(feito0 && feito1)) begin
            erros++;
            $display("FAIL rodada_timeout ciclo %0d: got granted0=%b granted1=%b, expected both", ciclo, feito0, feito1);
            barr.Req0 = 1'b0;
            barr.Req1 = 1'b0;
        end
    endtask

    initial begin
        bit         v0, v1, w0, w1;
        logic [7:0] a0, a1, d0, d1;

        Reset = 1'b1;
        barr.Req0 = 1'b1; barr.Escr0 = 1'b1; barr.Endereco0 = 8'h3C; barr.Dado0 = 8'hA5;
        barr.Req1 = 1'b0; barr.Escr1 = 1'b0; barr.Endereco1 = 8'h00; barr.Dado1 = 8'h00;

        aplicar_reset(2);
        rodada(1, 1, 8'h3C, 8'hA5, 0, 0, 8'h00, 8'h00, 0);
        rodada(1, 0, 8'h3C, 8'h11, 0, 0, 8'h00, 8'h00, 0);

        ocioso(3);
        aplicar_reset(2);
        rodada(1, 1, 8'hFF, 8'hC3, 1, 1, 8'h00, 8'h5A, 0);
        rodada(1, 1, 8'hFF, 8'h3C, 1, 1, 8'h00, 8'h96, 0);
        rodada(1, 0, 8'hFF, 8'h00, 1, 0, 8'h00, 8'h00, 0);

        rodada(0, 0, 8'h00, 8'h00, 1, 1, 8'h80, 8'h7E, 0);
        rodada(1, 0, 8'h80, 8'h00, 0, 0, 8'h00, 8'h00, 0);

        ocioso(3);
        rodada(1, 1, 8'h12, 8'h34, 1, 0, 8'h80, 8'h00, 1);

        ocioso(3);
        rodada(1, 0, 8'h3C, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        #1;
        Reset = 1'b1;
        fila.delete();
        em_curso = 0;
        @(negedge Clock);
        vetores++;
        if (barr.Pronto0 || barr.Ocupado || barr.DadoLido0 != 8'h00 || barr.Concedido0) begin
            erros++;
            $display("FAIL reset_acesso: got Pronto0=%b Ocupado=%b DadoLido0=%h, expected 0 0 00",
                     barr.Pronto0, barr.Ocupado, barr.DadoLido0);
        end
        Reset       = 1'b0;
        livre_mod   = ciclo;
        ultimo_mod  = 1'b1;
        lido_ref[0] = 8'h00;
        lido_ref[1] = 8'h00;

        for (int i = 0; i < 40; i++) begin
            v0 = ($urandom_range(0, 1) == 1);
            v1 = ($urandom_range(0, 1) == 1);
            if (!v0 && !v1) v0 = 1'b1;
            w0 = ($urandom_range(0, 1) == 1);
            w1 = ($urandom_range(0, 1) == 1);
            a0 = pool[$urandom_range(0, 5)];
            a1 = pool[$urandom_range(0, 5)];
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            rodada(v0, w0, a0, d0, v1, w1, a1, d1, int'($urandom_range(0, 4)));
            if ($urandom_range(0, 2) == 0) ocioso(int'($urandom_range(1, 4)));
        end

        ocioso(6);
        vetores++;
        if (fila.size() != 0) begin
            erros++;
            $display("FAIL fila_final: got %0d pending transactions, expected 0", fila.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end
endmodule
